// File: rtl/ps2_seq_pkg.sv
// ----------------------------------------------------------------------------
// ps2_seq_pkg
//  Shared types and constants for the PS/2 set-2 key sequencer.
//  - state_t : sequencer FSM states
//  - kind_t  : event kind carried through the event FIFO
//  - event_t : one queued key event {shft, kind, data} (11 bits)
//  - prefix bytes and the list of receiver status bytes that carry no key
// ----------------------------------------------------------------------------
package ps2_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_LOOK    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        K_CHAR = 2'd0,
        K_ENTR = 2'd1,
        K_BKSP = 2'd2
    } kind_t;

    typedef struct packed {
        logic       shft;
        kind_t      kind;
        logic [7:0] data;
    } event_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    // Keyboard status/response bytes that never start a key sequence.
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_OVR0   = 8'h00;
    localparam logic [7:0] PS2_OVR1   = 8'hFF;

    function automatic logic ps2_is_ignored(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK)  || (b == PS2_RESEND) ||
               (b == PS2_ECHO)   || (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// ----------------------------------------------------------------------------
// ps2_evt_fifo
//  First-word-fall-through FIFO of event_t. A push into a full FIFO is
//  accepted only if a pop happens in the same cycle; otherwise it is dropped
//  and o_drop pulses for that cycle.
//  Ports:
//   i_clk, i_rst  clock, async active-high reset (flushes the FIFO)
//   i_push, i_din push strobe and event
//   i_pop         pop request (ignored while empty)
//   o_dout        head event (zero while empty)
//   o_vld         FIFO not empty
//   o_drop        push discarded because the FIFO was full
// ----------------------------------------------------------------------------
module ps2_evt_fifo
    import ps2_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_push,
    input  event_t i_din,
    input  logic   i_pop,
    output event_t o_dout,
    output logic   o_vld,
    output logic   o_drop
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    event_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot the push needs.
    assign w_wr    = i_push & (~w_full | w_pop);
    assign o_drop  = i_push & w_full & ~w_pop;

    assign o_vld   = ~w_empty;
    assign o_dout  = w_empty ? event_t'('0) : r_mem[r_rp];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wp] <= i_din;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// ----------------------------------------------------------------------------
// ps2_key_sequencer
//  Turns PS/2 set-2 scan-code bytes into CHAR/ENTR/BKSP events. Strips the
//  E0/F0 prefixes, presents the resulting key code to an external keycode
//  table, tracks shift and queues events in a FWFT FIFO.
//  Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_byte, i_byte_vld    scan-code byte and its 1-cycle strobe
//   o_key                 key code to the table {E0/00, code}
//   i_char, i_shft,
//   i_entr, i_bksp        table results for o_key
//   o_data, o_kind,
//   o_shft, o_vld, i_rdy  FIFO head event and pop handshake
//   o_shift               current shift-held state
//   o_ovf, o_err, i_clr   sticky overflow / protocol error flags and clear
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | waiting for the first byte of a sequence
//  S_EXT     | E0 seen, waiting for F0 or the code byte
//  S_BRK     | F0 seen, waiting for the code byte
//  S_EXT_BRK | E0 F0 seen, waiting for the code byte
//  S_LOOK    | o_key is registered; sample the table and act (1 cycle)
// ----------------------------------------------------------------------------
module ps2_key_sequencer
    import ps2_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TMO_CYCLES = 100000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_vld,
    output logic [15:0] o_key,
    input  logic [7:0]  i_char,
    input  logic        i_shft,
    input  logic        i_entr,
    input  logic        i_bksp,
    output logic [7:0]  o_data,
    output logic [1:0]  o_kind,
    output logic        o_shft,
    output logic        o_vld,
    input  logic        i_rdy,
    output logic        o_shift,
    output logic        o_ovf,
    output logic        o_err,
    input  logic        i_clr
);
    localparam int              TW       = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYCLES - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_key;
    logic [15:0]   w_key_nxt;
    logic          r_brk;
    logic          w_brk_nxt;
    logic [TW-1:0] r_tmo;
    logic          w_tmo_run;
    logic          w_tmo_hit;
    logic          r_shift;
    logic          r_ovf;
    logic          r_err;
    logic          w_err_set;
    logic          w_shift_set;
    logic          w_shift_clr;
    logic          w_push;
    logic          w_drop;
    event_t        w_evt;
    event_t        w_head;

    assign w_tmo_hit = (r_tmo == TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_key_nxt   = r_key;
        w_brk_nxt   = r_brk;
        w_tmo_run   = 1'b0;
        w_err_set   = 1'b0;
        w_shift_set = 1'b0;
        w_shift_clr = 1'b0;
        w_push      = 1'b0;
        w_evt       = '0;
        w_evt.shft  = r_shift;

        case (r_state)
            S_IDLE: begin
                if (i_byte_vld) begin
                    if (i_byte == PS2_EXT) begin
                        w_state_nxt = S_EXT;
                    end else if (i_byte == PS2_BRK) begin
                        w_state_nxt = S_BRK;
                    end else if (!ps2_is_ignored(i_byte)) begin
                        w_key_nxt   = {8'h00, i_byte};
                        w_brk_nxt   = 1'b0;
                        w_state_nxt = S_LOOK;
                    end
                end
            end

            S_EXT: begin
                if (i_byte_vld) begin
                    if (i_byte == PS2_BRK) begin
                        w_state_nxt = S_EXT_BRK;
                    end else if (i_byte == PS2_EXT) begin
                        w_state_nxt = S_EXT;
                    end else begin
                        w_key_nxt   = {PS2_EXT, i_byte};
                        w_brk_nxt   = 1'b0;
                        w_state_nxt = S_LOOK;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_run = 1'b1;
                end
            end

            S_BRK, S_EXT_BRK: begin
                if (i_byte_vld) begin
                    if (i_byte == PS2_EXT || i_byte == PS2_BRK) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_key_nxt   = {(r_state == S_EXT_BRK) ? PS2_EXT : 8'h00, i_byte};
                        w_brk_nxt   = 1'b1;
                        w_state_nxt = S_LOOK;
                    end
                end else if (w_tmo_hit) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_run = 1'b1;
                end
            end

            S_LOOK: begin
                // The table is driven from r_key, so its answer is valid here.
                if (i_byte_vld) begin
                    w_err_set = 1'b1;
                end
                if (!r_brk) begin
                    if (i_shft) begin
                        w_shift_set = 1'b1;
                    end else if (i_entr) begin
                        w_push     = 1'b1;
                        w_evt.kind = K_ENTR;
                    end else if (i_bksp) begin
                        w_push     = 1'b1;
                        w_evt.kind = K_BKSP;
                    end else if (i_char != 8'h00) begin
                        w_push     = 1'b1;
                        w_evt.kind = K_CHAR;
                        w_evt.data = i_char;
                    end
                end else if (i_shft) begin
                    w_shift_clr = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_brk   <= 1'b0;
            r_tmo   <= '0;
            r_shift <= 1'b0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_key   <= w_key_nxt;
            r_brk   <= w_brk_nxt;
            // Cleared whenever a prefix state is entered, left or refreshed.
            r_tmo   <= w_tmo_run ? r_tmo + TW'(1) : '0;
            if (w_shift_set) begin
                r_shift <= 1'b1;
            end else if (w_shift_clr) begin
                r_shift <= 1'b0;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (i_clr) begin
                r_err <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    ps2_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (w_push),
        .i_din  (w_evt),
        .i_pop  (i_rdy),
        .o_dout (w_head),
        .o_vld  (o_vld),
        .o_drop (w_drop)
    );

    assign o_key   = r_key;
    assign o_data  = w_head.data;
    assign o_kind  = w_head.kind;
    assign o_shft  = w_head.shft;
    assign o_shift = r_shift;
    assign o_ovf   = r_ovf;
    assign o_err   = r_err;

endmodule
